mux_stream_nto1: RTL and testbench
==================================

// Module: mux_stream_nto1
//
// PURPOSE
// - Parametrised N-channel, WIDTH-bit stream multiplexer. Successor to the single-bit 2:1 mux.
// - Two selection modes: fixed channel select and round-robin arbitration.
// - Valid/ready handshake on every input channel and on the output.
// - Registered output stage. Sits between several producer streams and one shared consumer.
//
// PARAMETERS
// - N_CH   4  number of input channels, 2..16
// - WIDTH  8  data bits per channel
// - SELW   2  select/channel-id width; must equal $clog2(N_CH)
//
// PORTS
// - clk        in   1             rising-edge clock; the only clock
// - rst        in   1             synchronous reset, active-high
// - mode       in   1             0 = fixed select, 1 = round-robin
// - sel        in   SELW          channel index used when mode=0
// - in_valid   in   N_CH          per-channel valid
// - in_data    in   N_CH*WIDTH    channel i occupies bits [i*WIDTH +: WIDTH]
// - in_last    in   N_CH          per-channel end-of-packet; used only with LAST_LOCK_EN
// - in_ready   out  N_CH          per-channel ready; combinational
// - out_valid  out  1             output register holds a beat
// - out_data   out  WIDTH         registered data
// - out_ch     out  SELW          source channel of the held beat
// - out_ready  in   1             consumer ready
//
// BEHAVIOUR
// - Reset values: out_valid=0, out_data=0, out_ch=0, rr_ptr=N_CH-1, FSM in ARB.
// - Reset mid-operation discards any held beat.
// - Load enable: ld = !out_valid || out_ready. This gives full throughput: one beat per cycle.
// - Channel pick, recomputed every cycle:
//   - mode=0: pick = sel.
//   - mode=0 with sel >= N_CH: no channel is picked and all in_ready = 0.
//   - mode=1: pick = first i with in_valid[i] high, searching rr_ptr+1, rr_ptr+2, ... and wrapping modulo N_CH.
//   - mode=1 with no valid channel: no pick.
// - Ready: in_ready[i] = ld && (i == pick). At most one in_ready bit is high in any cycle.
// - Transfer on channel i when in_valid[i] && in_ready[i]:
//   - next cycle out_valid=1, out_data=in_data[i], out_ch=i;
//   - rr_ptr <= i, updated only on a transfer in mode=1.
// - Output beat consumed (out_valid && out_ready) with no new transfer: out_valid <= 0.
// - Consume and load in the same cycle: the register is overwritten with the new beat and out_valid stays 1.
// - Stall (out_valid && !out_ready): out_data and out_ch hold stable and all in_ready = 0.
// - Latency: input transfer to out_valid is exactly 1 cycle.
// - mode or sel changes take effect on the same-cycle pick. A held output beat is never altered.
// - Data passes through bit-exact. No width conversion.
// - FSM states:
//   - ARB: arbitrate as above.
//   - LOCK: exists only with LAST_LOCK_EN.
//
// CONFIGURATION
// - LAST_LOCK_EN defined:
//   - ARB -> LOCK when a beat transfers with in_last[i]=0. The locked channel index is stored.
//   - In LOCK, pick = locked channel regardless of mode, sel and other valids.
//   - LOCK -> ARB when a beat with in_last=1 transfers from the locked channel.
//   - rr_ptr updates only when the lock is released.
//   - mode/sel changes are deferred until the packet ends.
// - LAST_LOCK_EN undefined:
//   - in_last is ignored. The FSM stays in ARB. Arbitration happens per beat.
//
// TESTING
// - Reset: assert rst 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0 during reset.
// - Fixed mode: mode=0, sel=2, ch2 sends 0xA5, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, out_ch=2; in_ready[0,1,3] stay 0.
// - Round-robin fairness:
//   - mode=1, all 4 valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,... one beat per cycle.
//   - Same setup with ch1 idle -> sequence 0,2,3,0.
// - Backpressure:
//   - out_valid=1 with 0x3C, out_ready=0 for 3 cycles -> out_data holds 0x3C and in_ready=0.
//   - out_ready=1 -> next beat loads in the same cycle with no bubble.
// - Out-of-range select: N_CH=3, mode=0, sel=3 -> no transfer and in_ready=0 indefinitely.
// - LAST_LOCK_EN: mode=1, ch0 sends a 3-beat packet (last on beat 3) while ch1 is valid -> out_ch=0,0,0, then 1. Without the macro -> 0,1,0,1.

Source files
------------

// File: rtl/mux_stream_nto1_if.sv
// Stream bundle between N producers, the N:1 mux and one consumer.
// master = environment driving the producers/consumer ready; slave = the mux.
interface mux_stream_nto1_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int SELW  = 2
);
  logic                  mode;
  logic [SELW-1:0]       sel;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_last;
  logic [N_CH-1:0]       in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [SELW-1:0]       out_ch;
  logic                  out_ready;

  modport master (
    output mode, sel, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  mode, sel, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/mux_stream_nto1.sv
// N:1 valid/ready stream mux with fixed-select or round-robin pick and a registered output; 1-cycle latency.
// Define LAST_LOCK_EN to hold a channel for a whole packet (until in_last); otherwise arbitration is per beat.
module mux_stream_nto1 #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int SELW  = 2
) (
  input logic               clk,
  input logic               rst,
  mux_stream_nto1_if.slave  bus
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

  logic             ld;
  logic             locked;
  logic [SELW-1:0]  lock_ch;
  logic [SELW-1:0]  pick;
  logic             pick_vld;
  logic             pick_in_vld;
  logic [WIDTH-1:0] pick_dat;
  logic             pick_last;
  logic             xfer;
  logic             rr_upd;

  // Reset also blocks acceptance so nothing is consumed while rst is high.
  assign ld = !rst && (!out_valid_q || bus.out_ready);

  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    if (locked) begin
      pick     = lock_ch;
      pick_vld = 1'b1;
    end else if (!bus.mode) begin
      pick     = bus.sel;
      pick_vld = (int'(bus.sel) < N_CH);
    end else begin
      // Two passes: channels above rr_ptr first, then wrap to the ones at or below it.
      for (int i = 0; i < N_CH; i++) begin
        if (!pick_vld && bus.in_valid[i] && (SELW'(i) > rr_ptr_q)) begin
          pick     = SELW'(i);
          pick_vld = 1'b1;
        end
      end
      for (int i = 0; i < N_CH; i++) begin
        if (!pick_vld && bus.in_valid[i] && (SELW'(i) <= rr_ptr_q)) begin
          pick     = SELW'(i);
          pick_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pick_dat    = '0;
    pick_in_vld = 1'b0;
    pick_last   = 1'b0;
    bus.in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (SELW'(i) == pick) begin
        pick_dat    = bus.in_data[i*WIDTH +: WIDTH];
        pick_in_vld = bus.in_valid[i];
        pick_last   = bus.in_last[i];
        bus.in_ready[i] = ld && pick_vld;
      end
    end
  end

  assign xfer = ld && pick_vld && pick_in_vld;

`ifdef LAST_LOCK_EN
  typedef enum logic {ARB, LOCK} state_e;

  state_e          state_q, state_d;
  logic [SELW-1:0] lock_ch_q, lock_ch_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB;
      lock_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    case (state_q)
      ARB: begin
        if (xfer && !pick_last) begin
          state_d   = LOCK;
          lock_ch_d = pick;
        end
      end
      LOCK: begin
        if (xfer && pick_last) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  assign locked  = (state_q == LOCK);
  assign lock_ch = lock_ch_q;
  // The pointer only moves once a packet has fully gone through.
  assign rr_upd  = xfer && bus.mode && pick_last;
`else
  logic unused_last;

  assign unused_last = ^{bus.in_last, pick_last};
  assign locked      = 1'b0;
  assign lock_ch     = '0;
  assign rr_upd      = xfer && bus.mode;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = pick_dat;
      out_ch_d    = pick;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (rr_upd) rr_ptr_d = pick;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= SELW'(N_CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_stream_nto1.sv
// Directed bench for mux_stream_nto1: a 4-channel instance for the main traffic and a
// 3-channel instance parked on an out-of-range select.
module tb_mux_stream_nto1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mux_stream_nto1_if #(.N_CH(4), .WIDTH(8), .SELW(2)) b4 ();
  mux_stream_nto1_if #(.N_CH(3), .WIDTH(8), .SELW(2)) b3 ();

  mux_stream_nto1 #(.N_CH(4), .WIDTH(8), .SELW(2)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
  mux_stream_nto1 #(.N_CH(3), .WIDTH(8), .SELW(2)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_lock [4];
    logic       x0;
    int         cnt;

`ifdef LAST_LOCK_EN
    exp_lock[0] = 2'd0; exp_lock[1] = 2'd0; exp_lock[2] = 2'd0; exp_lock[3] = 2'd1;
`else
    exp_lock[0] = 2'd0; exp_lock[1] = 2'd1; exp_lock[2] = 2'd0; exp_lock[3] = 2'd1;
`endif

    b4.mode = 1'b0; b4.sel = 2'd0; b4.in_valid = 4'hF; b4.in_last = 4'hF;
    b4.in_data = 32'h13121110; b4.out_ready = 1'b1;
    b3.mode = 1'b0; b3.sel = 2'd3; b3.in_valid = 3'b111; b3.in_last = 3'b111;
    b3.in_data = 24'hC2C1C0; b3.out_ready = 1'b1;

    // Reset held for two cycles with every channel valid.
    #1;
    chk("rst_in_ready_comb", 32'(b4.in_ready), 32'h0);
    tick();
    tick();
    chk("rst_out_valid", 32'(b4.out_valid), 32'h0);
    chk("rst_out_data", 32'(b4.out_data), 32'h0);
    chk("rst_out_ch", 32'(b4.out_ch), 32'h0);
    chk("rst_in_ready", 32'(b4.in_ready), 32'h0);

    // Fixed select of channel 2.
    rst = 1'b0;
    b4.sel = 2'd2; b4.in_valid = 4'b0100; b4.in_data = 32'h13A51110;
    #1;
    chk("fix_in_ready", 32'(b4.in_ready), 32'h4);
    tick();
    chk("fix_out_valid", 32'(b4.out_valid), 32'h1);
    chk("fix_out_data", 32'(b4.out_data), 32'hA5);
    chk("fix_out_ch", 32'(b4.out_ch), 32'h2);
    b4.in_valid = 4'b0000;
    #1;
    chk("fix_other_ready", 32'(b4.in_ready & 4'b1011), 32'h0);
    chk("oor_in_ready_a", 32'(b3.in_ready), 32'h0);
    tick();
    chk("fix_drain", 32'(b4.out_valid), 32'h0);

    // Round-robin with all four channels busy: 0,1,2,3,0,1,2,3.
    b4.mode = 1'b1; b4.in_valid = 4'hF; b4.in_data = 32'h13121110;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_all_ch", 32'(b4.out_ch), 32'(k % 4));
      chk("rr_all_data", 32'(b4.out_data), 32'(8'h10 + k % 4));
    end
    chk("rr_all_valid", 32'(b4.out_valid), 32'h1);

    // Channel 1 idle: 0,2,3,0.
    b4.in_valid = 4'b1101;
    tick(); chk("rr_skip_0", 32'(b4.out_ch), 32'h0);
    tick(); chk("rr_skip_1", 32'(b4.out_ch), 32'h2);
    tick(); chk("rr_skip_2", 32'(b4.out_ch), 32'h3);
    tick(); chk("rr_skip_3", 32'(b4.out_ch), 32'h0);
    chk("oor_out_valid_a", 32'(b3.out_valid), 32'h0);

    // Backpressure on a held 0x3C beat, then release with no bubble.
    b4.mode = 1'b0; b4.sel = 2'd1; b4.in_valid = 4'b0010; b4.in_data = 32'h13123C10;
    #1;
    chk("bp_in_ready_pre", 32'(b4.in_ready), 32'h2);
    tick();
    chk("bp_load", 32'(b4.out_data), 32'h3C);
    b4.out_ready = 1'b0; b4.in_data = 32'h13125A10;
    #1;
    chk("bp_stall_ready0", 32'(b4.in_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_data", 32'(b4.out_data), 32'h3C);
      chk("bp_hold_ch", 32'(b4.out_ch), 32'h1);
      chk("bp_hold_valid", 32'(b4.out_valid), 32'h1);
      chk("bp_hold_ready", 32'(b4.in_ready), 32'h0);
    end
    b4.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(b4.in_ready), 32'h2);
    tick();
    chk("bp_next_data", 32'(b4.out_data), 32'h5A);
    chk("bp_next_valid", 32'(b4.out_valid), 32'h1);
    b4.in_valid = 4'b0000;
    tick();
    chk("bp_drain", 32'(b4.out_valid), 32'h0);

    // Packet from ch0 competing with ch1; rr_ptr first parked on ch3.
    b4.mode = 1'b1; b4.in_valid = 4'b1000; b4.in_last = 4'hF; b4.in_data = 32'h03020100;
    tick();
    chk("lock_pre_ch", 32'(b4.out_ch), 32'h3);
    b4.in_valid = 4'b0011; b4.in_last = 4'b0010; b4.in_data = 32'h030201B1;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      x0 = b4.in_valid[0] && b4.in_ready[0];
      tick();
      chk("lock_seq_ch", 32'(b4.out_ch), 32'(exp_lock[k]));
      if (k == 0) chk("lock_first_data", 32'(b4.out_data), 32'hB1);
      if (x0) begin
        cnt++;
        b4.in_data[7:0] = 8'(8'hB1 + cnt);
        b4.in_last[0]   = (cnt == 2);
        if (cnt == 3) b4.in_valid[0] = 1'b0;
      end
    end

    // Reset mid-operation drops the held beat.
    b4.in_valid = 4'hF;
    tick();
    chk("mid_loaded", 32'(b4.out_valid), 32'h1);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(b4.out_valid), 32'h0);
    chk("mid_rst_data", 32'(b4.out_data), 32'h0);
    chk("mid_rst_ch", 32'(b4.out_ch), 32'h0);
    rst = 1'b0;

    // Out-of-range select never transferred; an in-range select then works.
    chk("oor_out_valid_b", 32'(b3.out_valid), 32'h0);
    chk("oor_in_ready_b", 32'(b3.in_ready), 32'h0);
    b3.sel = 2'd1;
    #1;
    chk("inr_in_ready", 32'(b3.in_ready), 32'h2);
    tick();
    chk("inr_out_ch", 32'(b3.out_ch), 32'h1);
    chk("inr_out_data", 32'(b3.out_data), 32'hC1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
